// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared 16-bit ALU between two requesters,
// with a one-entry registered response buffer and the architected ZVN flag register.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [3:0]  req0_opcode,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [3:0]  req1_opcode,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        req1_ready,
   output logic [3:0]  alu_opcode,
   output logic [15:0] alu_in1,
   output logic [15:0] alu_in2,
   input  logic [15:0] alu_out,
   input  logic [2:0]  alu_flags,
   input  logic [2:0]  alu_en,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [15:0] rsp_data,
   output logic [2:0]  rsp_flags,
   input  logic        rsp_ready,
   output logic [2:0]  flags
);

   logic last_grant;
   logic any_req;
   logic grant;
   logic can_accept;
   logic accept;

   assign any_req    = req0_valid | req1_valid;
   assign can_accept = ~rsp_valid | rsp_ready;
   // rst_n gates acceptance so no ready is raised while reset is held
   assign accept     = rst_n & any_req & can_accept;
   assign req0_ready = accept & ~grant;
   assign req1_ready = accept & grant;

   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   always_comb begin
      alu_opcode = '0;
      alu_in1    = '0;
      alu_in2    = '0;
      if (any_req) begin
         if (grant) begin
            alu_opcode = req1_opcode;
            alu_in1    = req1_a;
            alu_in2    = req1_b;
         end else begin
            alu_opcode = req0_opcode;
            alu_in1    = req0_a;
            alu_in2    = req0_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_flags  <= '0;
         flags      <= '0;
         last_grant <= 1'b1;
      end else if (accept) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= grant;
         rsp_data   <= alu_out;
         rsp_flags  <= alu_flags;
         last_grant <= grant;
         // only the execute stage owns the architected flags
         if (!grant) begin
            flags <= (flags & ~alu_en) | (alu_flags & alu_en);
         end
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the ALU side, a model
// predicts grants and responses, and a separate monitor checks the response buffer.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [3:0]  req0_opcode = '0, req1_opcode = '0;
   logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_ready, req1_ready;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_in1, alu_in2, alu_out;
   logic [2:0]  alu_flags, alu_en;
   logic        rsp_valid, rsp_id, rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_flags, flags;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ready(req1_ready),
      .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_out(alu_out), .alu_flags(alu_flags), .alu_en(alu_en),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
      .rsp_ready(rsp_ready), .flags(flags)
   );

   // Behavioural ALU: returns {result, {Z,V,N}, flag-enable mask}
   function automatic logic [21:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      logic [15:0] r;
      logic        v;
      logic [2:0]  en;
      v = 1'b0;
      case (op)
         4'h0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
         4'h1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
         4'h2: r = a ^ b;
         4'h3: r = a & b;
         4'h4: r = a | b;
         4'h5: r = ~a;
         4'h6: r = a << 1;
         4'h7: r = a >> 1;
         default: r = b ^ {op, 12'h000};
      endcase
      en = (op <= 4'h1) ? 3'b111 : (op <= 4'h7) ? 3'b100 : 3'b000;
      return {r, (r == 16'h0000), v, r[15], en};
   endfunction

   assign {alu_out, alu_flags, alu_en} = alu_f(alu_opcode, alu_in1, alu_in2);

   typedef struct {
      logic        id;
      logic [15:0] data;
      logic [2:0]  rflags;
   } rsp_t;

   rsp_t exp_q[$];

   logic       m_last = 1'b1;
   logic       m_full = 1'b0;
   logic [2:0] m_flags = 3'b000;
   logic       acc0, acc1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive at negedge, then compare combinational outputs
   // and current state against the model and advance the model.
   task automatic drive(input logic v0, input logic [3:0] op0, input logic [15:0] a0,
                        input logic [15:0] b0, input logic v1, input logic [3:0] op1,
                        input logic [15:0] a1, input logic [15:0] b1, input logic rr);
      logic        any, g, can, e0, e1;
      logic [3:0]  eop;
      logic [15:0] ea, eb;
      logic [21:0] res;
      rsp_t        item;
      @(negedge clk);
      req0_valid = v0; req0_opcode = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_opcode = op1; req1_a = a1; req1_b = b1;
      rsp_ready = rr;
      #1;
      chk("rsp_valid", rsp_valid, m_full);
      chk("flags", flags, m_flags);
      any = v0 | v1;
      if (v0 && v1)  g = ~m_last;
      else           g = v1 & ~v0;
      can = ~m_full | rr;
      e0  = rst_n & any & can & ~g;
      e1  = rst_n & any & can & g;
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      eop = !any ? 4'h0 : g ? op1 : op0;
      ea  = !any ? 16'h0 : g ? a1 : a0;
      eb  = !any ? 16'h0 : g ? b1 : b0;
      chk("alu_drive", {alu_opcode, alu_in1, alu_in2}, {eop, ea, eb});
      acc0 = e0;
      acc1 = e1;
      if (e0 || e1) begin
         res = g ? alu_f(op1, a1, b1) : alu_f(op0, a0, b0);
         item.id = g;
         item.data = res[21:6];
         item.rflags = res[5:3];
         exp_q.push_back(item);
         if (!g) m_flags = (m_flags & ~res[2:0]) | (res[5:3] & res[2:0]);
         m_last = g;
         m_full = 1'b1;
      end else if (m_full && rr) begin
         m_full = 1'b0;
      end
   endtask

   // Monitor: whenever a response is presented, compare against the queue head;
   // pop it when the consumer takes it.
   initial begin
      rsp_t h;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got id=%0d data=%0h, no response expected",
                        rsp_id, rsp_data);
            end else begin
               h = exp_q[0];
               chk("rsp", {rsp_id, rsp_data, rsp_flags}, {h.id, h.data, h.rflags});
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic        p0v, p1v;
      logic [3:0]  p0op, p1op;
      logic [15:0] p0a, p0b, p1a, p1b;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Requester 1 isolation: flags stay 000
      drive(0, 4'h0, 16'h0, 16'h0, 1, 4'h1, 16'h5, 16'h5, 1);
      chk("iso_ready1", req1_ready, 1);
      drive(0, 4'h0, 16'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 1);
      chk("iso_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 16'h0000});
      chk("iso_flags", flags, 3'b000);

      // Single add, then masked XOR update
      drive(1, 4'h0, 16'h7FFF, 16'h0001, 0, 4'h0, 16'h0, 16'h0, 1);
      chk("add_ready0", req0_ready, 1);
      drive(1, 4'h2, 16'h1234, 16'h1234, 0, 4'h0, 16'h0, 16'h0, 1);
      chk("add_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 16'h8000});
      chk("add_flags", flags, 3'b011);
      drive(0, 4'h0, 16'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 0);
      chk("xor_rsp", rsp_data, 16'h0000);
      chk("xor_flags", flags, 3'b111);

      // Backpressure: buffer full, consumer stalled, req0 held for 3 cycles
      repeat (3) begin
         drive(1, 4'h9, 16'hAAAA, 16'h5555, 0, 4'h0, 16'h0, 16'h0, 0);
         chk("bp_ready0", req0_ready, 0);
         chk("bp_data", rsp_data, 16'h0000);
      end
      drive(1, 4'h9, 16'hAAAA, 16'h5555, 0, 4'h0, 16'h0, 16'h0, 1);
      chk("bp_release_ready0", req0_ready, 1);
      drive(0, 4'h0, 16'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 0);
      chk("bp_new_rsp", {rsp_valid, rsp_data}, {1'b1, 16'h5555 ^ 16'h9000});

      // Asynchronous reset mid-cycle with a full buffer and flags=111
      chk("pre_reset", {rsp_valid, flags}, {1'b1, 3'b111});
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_state", {rsp_valid, rsp_id, rsp_data, rsp_flags, flags},
          {1'b0, 1'b0, 16'h0000, 3'b000, 3'b000});
      exp_q.delete();
      m_last = 1'b1; m_full = 1'b0; m_flags = 3'b000;
      drive(1, 4'h3, 16'h00FF, 16'h0F0F, 1, 4'h4, 16'h1000, 16'h0001, 1);
      chk("reset_no_ready", {req0_ready, req1_ready}, 2'b00);
      rst_n = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Round-robin with both requesters always valid
      for (int unsigned i = 0; i < 6; i++) begin
         drive(1, 4'(i), 16'(i * 16'h111), 16'h0101, 1, 4'(i + 8), 16'h2222, 16'(i), 1);
         chk("rr_grant", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end

      // Randomized traffic; un-granted requests are held stable
      p0v = 0; p1v = 0; p0op = 0; p1op = 0; p0a = 0; p0b = 0; p1a = 0; p1b = 0;
      acc0 = 0; acc1 = 0;
      for (int unsigned i = 0; i < 400; i++) begin
         if (!p0v || acc0) begin
            p0v = ($urandom % 4) != 0; p0op = 4'($urandom);
            p0a = ($urandom % 5 == 0) ? 16'h7FFF : 16'($urandom);
            p0b = ($urandom % 5 == 0) ? p0a : 16'($urandom);
         end
         if (!p1v || acc1) begin
            p1v = ($urandom % 3) != 0; p1op = 4'($urandom);
            p1a = 16'($urandom); p1b = ($urandom % 4 == 0) ? p1a : 16'($urandom);
         end
         drive(p0v, p0op, p0a, p0b, p1v, p1op, p1a, p1b, ($urandom % 4) != 0);
      end

      // Drain and confirm every predicted response was observed
      repeat (3) drive(0, 4'h0, 16'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 1);
      @(negedge clk);
      #3;
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 16-bit ALU (opcodes 4'h0–4'hF, ZVN flags, per-opcode flag-enable mask). It sits between the execute stage (requester 0) and a secondary client such as address/debug logic (requester 1). It grants the single ALU round-robin and drives the ALU operands combinationally. It registers the result into a one-entry response buffer with valid/ready handshake and keeps the architected ZVN flag register, which only requester 0 may update.

## Interface
Parameters:
- none (widths fixed: data 16, opcode 4, flags 3)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending
- req0_opcode / req1_opcode  in  4  ALU opcode
- req0_a, req0_b / req1_a, req1_b  in  16  operands
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- alu_opcode  out  4  to shared ALU Opcode
- alu_in1, alu_in2  out  16  to shared ALU operands
- alu_out  in  16  ALU result
- alu_flags  in  3  ALU flags {Z,V,N} as bits [2],[1],[0]
- alu_en  in  3  ALU flag-write mask, same bit order
- rsp_valid  out  1  response buffer full
- rsp_id  out  1  requester of buffered result
- rsp_data  out  16  buffered result
- rsp_flags  out  3  raw alu_flags captured with the result
- rsp_ready  in  1  consumer takes response
- flags  out  3  architected ZVN register

## Operation
- can_accept = !rsp_valid || rsp_ready.
- Arbitration uses last_grant, a 1-bit register:
  - only req0_valid: grant 0.
  - only req1_valid: grant 1.
  - both valid: grant !last_grant.
  - neither valid: no grant.
- reqN_ready = can_accept && grant==N. At most one ready is asserted per cycle.
- ALU drive is combinational from the granted request: opcode, a, b. With no grant, alu_opcode, alu_in1 and alu_in2 are 0.
- An accept (valid && ready) loads, on that clock edge:
  - rsp_data <= alu_out; rsp_flags <= alu_flags; rsp_id <= grant; rsp_valid <= 1; last_grant <= grant.
  - If grant==0: flags <= (flags & ~alu_en) | (alu_flags & alu_en), per-bit masked update.
  - If grant==1: flags is unchanged.
- A response handshake (rsp_valid && rsp_ready) with no accept in the same cycle clears rsp_valid. rsp_data, rsp_id and rsp_flags hold their last values.
- Response handshake and accept in the same cycle: the buffer reloads with the new result and rsp_valid stays 1 (back-to-back throughput of 1 per cycle).
- No accept: last_grant is unchanged. An un-granted request is not dropped; the requester holds valid, opcode and operands stable until ready.
- Opcodes 4'h8–4'hF pass through unmodified. The flag effect is whatever alu_en reports (4'h0 and 4'h1 give 3'b111; 4'h2–4'h7 give 3'b100; others give 3'b000).

## Timing
- Reset (rst_n low, asynchronous) sets:
  - rsp_valid=0, rsp_data=16'h0000, rsp_id=0, rsp_flags=3'b000.
  - flags=3'b000, last_grant=1, so requester 0 wins the first tie.
- Outputs during reset: reqN_ready are 0 because of the reset-state gating. ALU drive follows the combinational rules.
- Latency: accept in cycle T gives rsp_valid=1 with data in cycle T+1. The flags update is visible in T+1.
- Ready depends combinationally on reqN_valid and rsp_ready. No registered stall bubble.
- Backpressure: rsp_valid=1 with rsp_ready=0 forces both readies to 0. ALU drive still follows the arbitration winner, but nothing is captured.
- Reset asserted mid-operation discards any buffered response. There is no partial flag update.

## Test plan
- Single add: req0 opcode 4'h0, a=16'h7FFF, b=16'h0001, rsp_ready=1 -> req0_ready=1 in T. In T+1: rsp_valid=1, rsp_id=0, rsp_data=16'h8000, flags=3'b011 (V,N).
- Masked flag update: after the test above, req0 opcode 4'h2 (XOR), a=b=16'h1234 -> rsp_data=0, flags=3'b111 (Z set; V,N retained because alu_en=3'b100).
- Requester 1 isolation: flags=3'b000, req1 opcode 4'h1, a=b=5 -> rsp_data=0, rsp_id=1, flags remain 3'b000.
- Round-robin: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id alternates with one result per cycle.
- Backpressure: rsp_ready=0 with rsp_valid=1 for 3 cycles, req0 valid -> req0_ready=0 and rsp_data stable. When rsp_ready rises, the handshake and accept happen in the same cycle and the new result appears next cycle.
- Async reset: assert rst_n=0 mid-cycle with rsp_valid=1 and flags=3'b111 -> rsp_valid=0 and flags=3'b000 immediately. After release, first tie grants requester 0.
